// File: rtl/adder_subs_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : adder_subs_multicycle
// Description : WIDTH-bit adder/subtractor that walks the operands in
//               CHUNK-bit slices, LSB slice first, one slice per clock, with a
//               registered carry between slices. start/busy/done handshake,
//               carry-out and signed-overflow flags.
//               Optional macro ADDSUB_ACCUM_EN adds port acc: when set on an
//               accepted start, operand A is taken from the current result s.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_subs_multicycle #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
`ifdef ADDSUB_ACCUM_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  c_LAST       = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] c_SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;        // B already inverted for subtract
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;

  logic             w_accept;
  logic [WIDTH-1:0] w_a_src;
  logic [31:0]      w_sh;
  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK:0]   w_sum_full;
  logic [CHUNK-1:0] w_sl;
  logic             w_c;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_s_merged;

  assign w_accept = (r_state == ST_IDLE) && start;

`ifdef ADDSUB_ACCUM_EN
  assign w_a_src = acc ? r_s : a;
`else
  assign w_a_src = a;
`endif

  // Select the active slice of each operand and add it with the stored carry
  assign w_sh       = 32'(r_idx) * 32'(CHUNK);
  assign w_a_shift  = r_a >> w_sh;
  assign w_b_shift  = r_b >> w_sh;
  assign w_a_sl     = w_a_shift[CHUNK-1:0];
  assign w_b_sl     = w_b_shift[CHUNK-1:0];
  assign w_sum_full = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
  assign w_sl       = w_sum_full[CHUNK-1:0];
  assign w_c        = w_sum_full[CHUNK];
  // Carry into the slice MSB recovered from the MSB sum bit: s = a ^ b ^ cin
  assign w_cin_msb  = w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1] ^ w_sl[CHUNK-1];
  assign w_s_merged = (r_s & ~(c_SLICE_MASK << w_sh)) | (WIDTH'(w_sl) << w_sh);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (r_idx == c_LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture on accept, then one slice per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= w_a_src;
      r_b     <= sel ? ~b : b;
      r_carry <= sel;
      r_idx   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_s     <= w_s_merged;
      r_carry <= w_c;
      if (r_idx == c_LAST) begin
        // Index parks at 0 so non-power-of-two slice counts never overrun
        r_idx <= '0;
        r_co  <= w_c;
        r_ovf <= w_cin_msb ^ w_c;
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign s   = r_s;
  assign co  = r_co;
  assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder_subs_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_subs_multicycle
// Description : Scoreboard bench for adder_subs_multicycle. Expected results
//               come from plain-arithmetic add/subtract with sign rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_subs_multicycle;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
`ifdef ADDSUB_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             acc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  adder_subs_multicycle #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sel   (sel),
`ifdef ADDSUB_ACCUM_EN
    .acc   (acc),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    int               acc_cyc;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model_s = '0;
  bit               prev_done = 1'b0;

  // Reference: ordinary integer add/subtract, flags from operand/result signs
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic sub);
    exp_t             e;
    logic [WIDTH:0]   full;
    if (!sub) begin
      full = {1'b0, x} + {1'b0, y};
      e.co = full[WIDTH];
    end else begin
      full = {1'b0, x} - {1'b0, y};
      e.co = (x >= y);
    end
    e.s = full[WIDTH-1:0];
    if (!sub) e.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
    else      e.ovf = (x[WIDTH-1] != y[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      chk("busy_during_done", 64'(busy), 64'd1);
      chk("done_single_cycle", 64'(prev_done), 64'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done s=%0h co=%0d ovf=%0d exp=none", s, co, ovf);
      end else begin
        e = sb.pop_front();
        chk("result", {45'd0, s, co, ovf, 1'b0}, {45'd0, e.s, e.co, e.ovf, 1'b0});
        chk("latency", 64'(cyc - e.acc_cyc), 64'(NCHUNK));
      end
    end
    prev_done = done;
  end

  // Wait for IDLE, pulse start for one edge; optionally push expected result
  task automatic issue(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic ss, input logic ac, input bit push);
    int               n = 0;
    logic [WIDTH-1:0] opa;
    exp_t             e;
    @(posedge clk); #1;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout busy=%0d exp=0", busy);
    end
    a = aa; b = bb; sel = ss; acc = ac; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) begin
      opa = (ACC_EN && ac) ? model_s : aa;
      e = model(opa, bb, ss);
      e.acc_cyc = cyc;
      sb.push_back(e);
      model_s = e.s;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {45'd0, s, co, ovf, busy, done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sel = 1'b0; acc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst = 1'b0;

    // Directed cases
    issue(16'h1234, 16'h0FF1, 1'b0, 1'b0, 1'b1); drain();
    chk("hold_after_done", 64'(s), 64'h2225);
    issue(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1); drain();
    issue(16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b1); drain();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1); drain();
    issue(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1); drain();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1); drain();
    issue(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1); drain();

    // Start while busy (RUN cycle 2) and in DONE must be ignored
    issue(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("busy_in_done", 64'(busy), 64'd1);
    a = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_after_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("no_accept_from_done", 64'(busy), 64'd0);
    chk("result_kept", 64'(s), 64'h0007);
    drain();

    // Reset in the middle of RUN aborts without a done pulse
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero("reset_mid_run");
    rst = 1'b0;
    model_s = '0;
    repeat (8) @(posedge clk);
    #1;
    chk("idle_after_abort", 64'(busy), 64'd0);
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1); drain();
    chk("post_abort_sum", 64'(s), 64'h0002);

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
            ACC_EN ? 1'($urandom) : 1'b0, 1'b1);
    end
    drain();

`ifdef ADDSUB_ACCUM_EN
    issue(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1); drain();
    issue(16'hDEAD, 16'h0005, 1'b0, 1'b1, 1'b1); drain();
    chk("accum_add", 64'(s), 64'h0015);
    issue(16'hBEEF, 16'h0020, 1'b1, 1'b1, 1'b1); drain();
    chk("accum_sub", {47'd0, s, co}, {47'd0, 16'hFFF5, 1'b0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_subs_multicycle.md
Name: adder_subs_multicycle

Overview:
- Parametrised WIDTH-bit adder/subtractor that processes the operation in CHUNK-bit slices, LSB slice first, over several clock cycles.
- Uses one CHUNK-wide adder slice per cycle plus a registered carry chain, trading latency for area.
- Successor to the 4-bit combinational adder/subtractor, used in datapaths where a full-width carry chain misses timing.
- Adds a start/busy/done handshake plus carry-out and signed-overflow flags.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of slice cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- a  in  WIDTH  operand A, captured on an accepted start.
- b  in  WIDTH  operand B, captured on an accepted start.
- sel  in  1  0 = add (A+B); 1 = subtract (A-B), captured on an accepted start.
- busy  out  1  high while in RUN or DONE.
- done  out  1  one-cycle pulse; result valid.
- s  out  WIDTH  result.
- co  out  1  carry out of the MSB; for subtract, 1 = no borrow (A >= B unsigned).
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset: all outputs clear to 0 (busy, done, s, co, ovf). State goes to IDLE, slice index to 0, internal operand and carry registers to 0.
- FSM states and transitions:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after NCHUNK slice edges.
  - DONE -> IDLE unconditionally after 1 cycle.
- Accept edge (IDLE, start=1):
  - Latch A = a.
  - Latch Beff = sel ? ~b : b.
  - Set carry register = sel, index = 0.
  - Clear s, co and ovf.
- Each RUN edge:
  - Compute {c, slice} = A[idx*CHUNK +: CHUNK] + Beff[idx*CHUNK +: CHUNK] + carry.
  - Write slice into s[idx*CHUNK +: CHUNK]; carry <= c; idx++.
  - On the final slice (idx == NCHUNK-1): co <= c; ovf <= (carry into bit WIDTH-1) XOR c; state <= DONE.
- Latency: done=1 during the cycle following the NCHUNK-th RUN edge, i.e. NCHUNK edges after the accept edge. The bench measures 4 cycles at the default parameters. Throughput is one operation per NCHUNK+2 cycles.
- done is high only in DONE (exactly 1 cycle). s, co and ovf hold their values after DONE until the next accepted start.
- start in RUN or DONE is ignored, with no queuing. Operand changes after the accept edge have no effect.
- The s bit slices above the current index hold 0 during RUN (partial result visible); consumers use s only when done=1 or afterwards.
- rst during RUN or DONE aborts the operation immediately: reset values apply on that edge and no done pulse is produced.
- rst and start high in the same cycle: rst wins.
- CHUNK == WIDTH degenerates to one RUN cycle; the behaviour is otherwise identical.

Optional Feature:
- Macro: ADDSUB_ACCUM_EN.
- Defined:
  - Extra input port acc (1 bit) is added after sel.
  - On an accepted start with acc=1, operand A is taken from the current s register instead of port a. This gives a running accumulate/decrement, e.g. s = s ± b.
  - acc=0 behaves exactly like the base block.
- Undefined: the port acc does not exist; A always comes from a.

Test Plan:
- Add, default parameters: a=0x1234, b=0x0FF1, sel=0 -> done 4 cycles after the accept edge; s=0x2225, co=0, ovf=0; done high for exactly 1 cycle.
- Subtract with borrow: a=0x0005, b=0x0007, sel=1 -> s=0xFFFE, co=0, ovf=0. Then a=0xABCD, b=0xABCD, sel=1 -> s=0x0000, co=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, sel=0 -> s=0x8000, co=0, ovf=1. Then a=0x8000, b=0x0001, sel=1 -> s=0x7FFF, co=1, ovf=1.
- Start while busy: second start with a=0xFFFF at RUN cycle 2 -> ignored; first result unchanged. A start asserted in DONE is also ignored; busy stays high through DONE.
- Reset mid-operation: rst=1 at RUN cycle 2 -> next cycle all outputs 0, state IDLE, no done pulse. A following add 0x0001+0x0001 gives s=0x0002.
- ADDSUB_ACCUM_EN defined: run 0x0010+0x0000, then start acc=1, b=0x0005, sel=0 -> s=0x0015. Then acc=1, b=0x0020, sel=1 -> s=0xFFF5, co=0.
